hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the IF/ID/EX front end of the RV32IM core. Detects load-use hazards,
//  squashes wrong-path instructions on branch/jump redirect, and holds the pipe while a
//  multi-cycle M-extension op (DIV/REM) runs in EX. Drives stall/flush/bubble enables of the
//  PC, IF/ID and ID/EX registers; keeps saturating stall/flush performance counters.
// PARAMETERS
//  MD_TIMEOUT  40  max MD_WAIT cycles before abort; legal range 1..2**MD_CNT_W-1
//  MD_CNT_W    6   width of the MD_WAIT cycle counter
//  CNT_W       32  width of STALL_COUNT / FLUSH_COUNT
// PORTS
//  CLK           in   1      clock, rising edge
//  RST           in   1      synchronous active-high reset
//  ID_RS1        in   5      rs1 of instruction in ID
//  ID_RS2        in   5      rs2 of instruction in ID
//  ID_USES_RS1   in   1      ID instruction reads rs1
//  ID_USES_RS2   in   1      ID instruction reads rs2
//  ID_MULDIV     in   1      ID instruction is multi-cycle (DIV/DIVU/REM/REMU)
//  EX_RD         in   5      destination register of instruction in EX
//  EX_MEM_READ   in   1      EX instruction is a load
//  EX_REDIRECT   in   1      EX resolved taken branch or jump
//  EX_MULDIV_DONE in  1      multi-cycle unit result valid this cycle
//  PC_STALL      out  1      hold PC
//  IF_ID_STALL   out  1      hold IF/ID register
//  IF_ID_FLUSH   out  1      clear IF/ID register to NOP
//  ID_EX_STALL   out  1      hold ID/EX register
//  ID_EX_BUBBLE  out  1      load NOP into ID/EX register
//  MD_BUSY       out  1      state == MD_WAIT
//  MD_TIMEOUT_ERR out 1      sticky: a multi-cycle op exceeded MD_TIMEOUT
//  STALL_COUNT   out  CNT_W  cycles with PC_STALL=1, saturating
//  FLUSH_COUNT   out  CNT_W  cycles with IF_ID_FLUSH=1, saturating
// BEHAVIOUR
//  - Registered state {RUN, MD_WAIT}; md_cnt; counters; ERR. Control outputs combinational
//    from state + inputs (same-cycle effect). No added latency on the data path.
//  - RST=1: next state RUN, md_cnt=0, counters=0, ERR=0. While RST=1: IF_ID_FLUSH=1,
//    ID_EX_BUBBLE=1, all stalls 0, MD_BUSY=0; counters do not increment.
//  - LU = EX_MEM_READ & EX_RD!=0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
//  - Priority in RUN: EX_REDIRECT > LU > ID_MULDIV issue.
//  - RUN, EX_REDIRECT=1: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, no stalls; stay RUN (LU/MULDIV ignored).
//  - RUN, LU=1: PC_STALL=IF_ID_STALL=ID_EX_BUBBLE=1 for exactly that cycle; stay RUN
//    (bubble in EX clears the hazard next cycle).
//  - RUN, ID_MULDIV=1 (no redirect, no LU): no stalls this cycle (op moves to EX);
//    next state MD_WAIT, md_cnt=0.
//  - MD_WAIT: PC_STALL=IF_ID_STALL=ID_EX_STALL=1, MD_BUSY=1, md_cnt++ each cycle.
//    EX_REDIRECT and LU are ignored in MD_WAIT (EX holds the M-op, which never redirects).
//    EX_MULDIV_DONE=1: all stalls 0 that cycle, next RUN.
//    No done and md_cnt==MD_TIMEOUT-1: stalls 0 that cycle, ERR<=1 (sticky until RST), next RUN.
//    Done and timeout in the same cycle: done wins, ERR unchanged.
//  - Counters increment by 1 on qualifying cycles; hold at all-ones (no wrap).
//  - RST mid-MD_WAIT: abort to RUN next edge; in-flight op is discarded upstream.
// STRUCTURE
//  - Shared header hazard_defs.vh: state encodings (RUN=1'b0, MD_WAIT=1'b1), default MD_TIMEOUT.
//  - One sub-module sat_counter (param W; inputs CLK, RST, INC; output COUNT),
//    instantiated twice for STALL_COUNT and FLUSH_COUNT.
// TESTING
//  1 EX_MEM_READ=1, EX_RD=5, ID_RS1=5, USES_RS1=1 -> 1 cycle PC/IF_ID stall + bubble; STALL_COUNT=1.
//  2 Same with EX_RD=0 or USES_RS1=0 -> no stall; EX_REDIRECT=1 with LU -> flush only, stalls 0.
//  3 ID_MULDIV=1, EX_MULDIV_DONE after 33 MD_WAIT cycles -> stalls 32 cycles, drop on done cycle;
//    STALL_COUNT=32, state RUN next.
//  4 MD_TIMEOUT=8, never done -> 7 stall cycles, 8th cycle stalls 0, MD_TIMEOUT_ERR=1 sticky.
//  5 RST during MD_WAIT cycle 5 -> next cycle RUN, MD_BUSY=0, counters 0, ERR 0.
//  6 CNT_W=4, 20 LU cycles -> STALL_COUNT saturates at 15.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types and defaults for the IF/ID/EX hazard controller.
//   hc_state_e : sequencer state (RUN / MD_WAIT)
//   pipe_ctl_t : bundle of pipeline-register control enables
//   load_use() : load-use hazard detect between ID and EX
package hazard_controller_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } hc_state_e;

   localparam int MD_TIMEOUT_DEF = 40;
   localparam int MD_CNT_W_DEF   = 6;
   localparam int CNT_W_DEF      = 32;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_stall;
      logic id_ex_bubble;
   } pipe_ctl_t;

   // x0 is hardwired zero, so a load targeting it never creates a hazard.
   function automatic logic load_use(input logic [4:0] rs1,
                                     input logic [4:0] rs2,
                                     input logic       uses_rs1,
                                     input logic       uses_rs2,
                                     input logic [4:0] ex_rd,
                                     input logic       ex_mem_read);
      return ex_mem_read && (ex_rd != 5'd0) &&
             ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset, clears COUNT
//   INC   : add one this cycle (ignored once COUNT is all-ones)
//   COUNT : current value, holds at all-ones instead of wrapping
module sat_counter
   import hazard_controller_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         INC,
   output logic [W-1:0] COUNT
);

   always_ff @(posedge CLK) begin
      if (RST)
         COUNT <= '0;
      else if (INC && (COUNT != '1))
         COUNT <= COUNT + 1'b1;
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the IF/ID/EX front end of the RV32IM core.
// Detects load-use hazards, squashes wrong-path instructions on redirect and
// holds the front end while a multi-cycle DIV/REM op occupies EX.
//   CLK, RST                  : clock / synchronous active-high reset
//   ID_RS1/RS2, ID_USES_RS1/2 : source operands of the ID instruction
//   ID_MULDIV                 : ID instruction is a multi-cycle M-op
//   EX_RD, EX_MEM_READ        : destination / load flag of the EX instruction
//   EX_REDIRECT               : EX resolved a taken branch or jump
//   EX_MULDIV_DONE            : multi-cycle unit result valid
//   PC_STALL .. ID_EX_BUBBLE  : pipeline register enables (combinational)
//   MD_BUSY                   : waiting on a multi-cycle op
//   MD_TIMEOUT_ERR            : sticky, a multi-cycle op never finished
//   STALL_COUNT, FLUSH_COUNT  : saturating performance counters
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
   parameter int MD_CNT_W   = MD_CNT_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_USES_RS1,
   input  logic             ID_USES_RS2,
   input  logic             ID_MULDIV,
   input  logic [4:0]       EX_RD,
   input  logic             EX_MEM_READ,
   input  logic             EX_REDIRECT,
   input  logic             EX_MULDIV_DONE,
   output logic             PC_STALL,
   output logic             IF_ID_STALL,
   output logic             IF_ID_FLUSH,
   output logic             ID_EX_STALL,
   output logic             ID_EX_BUBBLE,
   output logic             MD_BUSY,
   output logic             MD_TIMEOUT_ERR,
   output logic [CNT_W-1:0] STALL_COUNT,
   output logic [CNT_W-1:0] FLUSH_COUNT
);

   localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

   hc_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic                err_q, err_d;
   pipe_ctl_t           ctl;
   logic                md_busy;
   logic                lu;

   assign lu = load_use(ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= RUN;
         md_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      ctl      = '0;
      md_busy  = 1'b0;
      state_d  = state_q;
      md_cnt_d = '0;
      err_d    = err_q;
      if (RST) begin
         // Keep wrong state out of the pipe while the core is held in reset.
         ctl.if_id_flush  = 1'b1;
         ctl.id_ex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (EX_REDIRECT) begin
                  // Wrong-path instructions in IF/ID and ID are dropped,
                  // so a hazard or M-op they carry is irrelevant.
                  ctl.if_id_flush  = 1'b1;
                  ctl.id_ex_bubble = 1'b1;
               end else if (lu) begin
                  // One bubble is enough: next cycle the load sits in MEM
                  // and forwarding covers the consumer.
                  ctl.pc_stall     = 1'b1;
                  ctl.if_id_stall  = 1'b1;
                  ctl.id_ex_bubble = 1'b1;
               end else if (ID_MULDIV) begin
                  // The M-op advances into EX this cycle; hold from next.
                  state_d = MD_WAIT;
               end
            end
            MD_WAIT: begin
               md_busy  = 1'b1;
               md_cnt_d = md_cnt_q + 1'b1;
               if (EX_MULDIV_DONE) begin
                  state_d = RUN;
               end else if (md_cnt_q == MD_LAST) begin
                  // Give up and release the pipe; flag it for software.
                  state_d = RUN;
                  err_d   = 1'b1;
               end else begin
                  ctl.pc_stall    = 1'b1;
                  ctl.if_id_stall = 1'b1;
                  ctl.id_ex_stall = 1'b1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign PC_STALL       = ctl.pc_stall;
   assign IF_ID_STALL    = ctl.if_id_stall;
   assign IF_ID_FLUSH    = ctl.if_id_flush;
   assign ID_EX_STALL    = ctl.id_ex_stall;
   assign ID_EX_BUBBLE   = ctl.id_ex_bubble;
   assign MD_BUSY        = md_busy;
   assign MD_TIMEOUT_ERR = err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .INC   (ctl.pc_stall),
      .COUNT (STALL_COUNT)
   );

   // Reset-time flushes are housekeeping, not pipeline events.
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .INC   (ctl.if_id_flush & ~RST),
      .COUNT (FLUSH_COUNT)
   );

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   localparam logic [6:0] PC  = 7'b1000000;
   localparam logic [6:0] IFS = 7'b0100000;
   localparam logic [6:0] FL  = 7'b0010000;
   localparam logic [6:0] EXS = 7'b0001000;
   localparam logic [6:0] BUB = 7'b0000100;
   localparam logic [6:0] BSY = 7'b0000010;
   localparam logic [6:0] ERR = 7'b0000001;
   localparam logic [6:0] STL = PC | IFS | EXS | BSY;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, md, mr, redir, done;

   wire        pc0, ifs0, fl0, exs0, bub0, bsy0, err0;
   wire        pc1, ifs1, fl1, exs1, bub1, bsy1, err1;
   wire [31:0] sc0, fc0;
   wire [3:0]  sc1, fc1;

   always #5 clk = ~clk;

   hazard_controller u_dut0 (
      .CLK(clk), .RST(rst), .ID_RS1(rs1), .ID_RS2(rs2), .ID_USES_RS1(u1), .ID_USES_RS2(u2),
      .ID_MULDIV(md), .EX_RD(rd), .EX_MEM_READ(mr), .EX_REDIRECT(redir), .EX_MULDIV_DONE(done),
      .PC_STALL(pc0), .IF_ID_STALL(ifs0), .IF_ID_FLUSH(fl0), .ID_EX_STALL(exs0),
      .ID_EX_BUBBLE(bub0), .MD_BUSY(bsy0), .MD_TIMEOUT_ERR(err0),
      .STALL_COUNT(sc0), .FLUSH_COUNT(fc0)
   );

   hazard_controller #(.MD_TIMEOUT(8), .MD_CNT_W(6), .CNT_W(4)) u_dut1 (
      .CLK(clk), .RST(rst), .ID_RS1(rs1), .ID_RS2(rs2), .ID_USES_RS1(u1), .ID_USES_RS2(u2),
      .ID_MULDIV(md), .EX_RD(rd), .EX_MEM_READ(mr), .EX_REDIRECT(redir), .EX_MULDIV_DONE(done),
      .PC_STALL(pc1), .IF_ID_STALL(ifs1), .IF_ID_FLUSH(fl1), .ID_EX_STALL(exs1),
      .ID_EX_BUBBLE(bub1), .MD_BUSY(bsy1), .MD_TIMEOUT_ERR(err1),
      .STALL_COUNT(sc1), .FLUSH_COUNT(fc1)
   );

   wire [6:0] ctl0 = {pc0, ifs0, fl0, exs0, bub0, bsy0, err0};
   wire [6:0] ctl1 = {pc1, ifs1, fl1, exs1, bub1, bsy1, err1};

   // sel: 0 = default instance, 1 = small instance (timeout 8, 4-bit counters), 2 = both
   typedef struct {
      string       name;
      int          sel;
      logic [6:0]  ctl;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t expq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t        e;
         logic [6:0]  a_ctl;
         logic [31:0] a_sc, a_fc;
         logic        bad;
         e     = expq.pop_front();
         a_ctl = (e.sel == 1) ? ctl1 : ctl0;
         a_sc  = (e.sel == 1) ? {28'd0, sc1} : sc0;
         a_fc  = (e.sel == 1) ? {28'd0, fc1} : fc0;
         bad   = (a_ctl !== e.ctl) || (a_sc !== e.sc) || (a_fc !== e.fc);
         if (e.sel == 2)
            bad = bad || (ctl1 !== e.ctl) || ({28'd0, sc1} !== e.sc) || ({28'd0, fc1} !== e.fc);
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b sc=%0d fc=%0d (small: ctl=%b sc=%0d fc=%0d), want ctl=%b sc=%0d fc=%0d",
                     e.name, a_ctl, a_sc, a_fc, ctl1, sc1, fc1, e.ctl, e.sc, e.fc);
         end
      end
   end

   task automatic check_now(input string n, input logic ok);
      n_tests++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: ctl0=%b sc0=%0d fc0=%0d ctl1=%b sc1=%0d fc1=%0d",
                  n, ctl0, sc0, fc0, ctl1, sc1, fc1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      u1 = 1'b0; u2 = 1'b0; md = 1'b0; mr = 1'b0; redir = 1'b0; done = 1'b0;
   endtask

   task automatic lu_in(input logic [4:0] r);
      mr = 1'b1; rd = r; rs1 = r; u1 = 1'b1;
   endtask

   task automatic expect_cyc(input string n, input int s, input logic [6:0] c,
                             input int sc, input int fc);
      exp_t e;
      e.name = n; e.sel = s; e.ctl = c; e.sc = 32'(sc); e.fc = 32'(fc);
      expq.push_back(e);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; idle_in();
      tick();
      #2;
      check_now("reset_state",
                (ctl0 === (FL | BUB)) && (ctl1 === (FL | BUB)) &&
                (sc0 === 32'd0) && (fc0 === 32'd0) && (sc1 === 4'd0) && (fc1 === 4'd0));
      expect_cyc("reset", 2, FL | BUB, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      tick();

      // ---- load-use detect ----
      do_reset();
      idle_in(); lu_in(5'd5);                      expect_cyc("lu_rs1", 0, PC | IFS | BUB, 0, 0);
      idle_in();                                   expect_cyc("lu_rs1_next", 0, 7'b0, 1, 0);
      idle_in(); mr = 1; rd = 5'd7; rs2 = 5'd7; u2 = 1; rs1 = 5'd3; u1 = 1;
                                                   expect_cyc("lu_rs2", 0, PC | IFS | BUB, 1, 0);
      idle_in();                                   expect_cyc("lu_rs2_next", 0, 7'b0, 2, 0);

      // ---- non-hazards and priority ----
      idle_in(); lu_in(5'd0);                      expect_cyc("lu_x0", 0, 7'b0, 2, 0);
      idle_in(); lu_in(5'd5); u1 = 0;              expect_cyc("lu_nouse", 0, 7'b0, 2, 0);
      idle_in(); lu_in(5'd5); mr = 0;              expect_cyc("lu_noload", 0, 7'b0, 2, 0);
      idle_in(); lu_in(5'd5); redir = 1;           expect_cyc("redir_over_lu", 0, FL | BUB, 2, 0);
      idle_in();                                   expect_cyc("redir_next", 0, 7'b0, 2, 1);
      idle_in(); lu_in(5'd5); md = 1;              expect_cyc("lu_over_md", 0, PC | IFS | BUB, 2, 1);
      idle_in();                                   expect_cyc("lu_over_md_next", 0, 7'b0, 3, 1);
      idle_in(); redir = 1; md = 1;                expect_cyc("redir_over_md", 0, FL | BUB, 3, 1);
      idle_in();                                   expect_cyc("redir_md_next", 0, 7'b0, 3, 2);

      // ---- multi-cycle op finishing after 33 wait cycles ----
      do_reset();
      idle_in(); md = 1;                           expect_cyc("md_issue", 0, 7'b0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         idle_in();
         if (i == 10) begin lu_in(5'd5); redir = 1; end
         expect_cyc((i == 10) ? "md_wait_ignore" : "md_wait", 0, STL, i, 0);
      end
      idle_in(); done = 1;                         expect_cyc("md_done", 0, BSY, 32, 0);
      idle_in();                                   expect_cyc("md_after", 0, 7'b0, 32, 0);

      // ---- timeout 8: done on the timeout cycle wins ----
      do_reset();
      idle_in(); md = 1;                           expect_cyc("to_issue", 1, 7'b0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         idle_in();                                expect_cyc("to_wait", 1, STL, i, 0);
      end
      idle_in(); done = 1;                         expect_cyc("to_done_tie", 1, BSY, 7, 0);
      idle_in();                                   expect_cyc("to_tie_noerr", 1, 7'b0, 7, 0);

      // ---- timeout 8: never done ----
      idle_in(); md = 1;                           expect_cyc("to_issue2", 1, 7'b0, 7, 0);
      for (int i = 0; i < 7; i++) begin
         idle_in();                                expect_cyc("to_wait2", 1, STL, 7 + i, 0);
      end
      idle_in();
      #2;
      check_now("to_expire_now",
                (pc1 === 1'b0) && (ifs1 === 1'b0) && (exs1 === 1'b0) &&
                (bsy1 === 1'b1) && (err1 === 1'b0));
      expect_cyc("to_expire", 1, BSY, 14, 0);
      #2;
      check_now("to_expire_err", (err1 === 1'b1) && (bsy1 === 1'b0) && (pc1 === 1'b0));
      for (int i = 0; i < 3; i++) begin
         idle_in();                                expect_cyc("to_err_sticky", 1, ERR, 14, 0);
      end
      idle_in(); md = 1;                           expect_cyc("err_issue", 1, ERR, 14, 0);
      idle_in();                                   expect_cyc("err_wait", 1, STL | ERR, 14, 0);
      idle_in(); done = 1;                         expect_cyc("err_done", 1, BSY | ERR, 15, 0);
      idle_in();                                   expect_cyc("err_after", 1, ERR, 15, 0);

      // ---- reset during the 5th wait cycle ----
      idle_in(); md = 1;                           expect_cyc("rst_issue", 1, ERR, 15, 0);
      for (int i = 0; i < 4; i++) begin
         idle_in();                                expect_cyc("rst_wait", 1, STL | ERR, 15, 0);
      end
      idle_in(); rst = 1;                          expect_cyc("rst_mid_wait", 1, FL | BUB | ERR, 15, 0);
      rst = 0;
      idle_in();                                   expect_cyc("rst_cleared", 1, 7'b0, 0, 0);
      idle_in();                                   expect_cyc("rst_run", 1, 7'b0, 0, 0);

      // ---- 4-bit counter saturation ----
      do_reset();
      for (int i = 0; i < 20; i++) begin
         idle_in(); lu_in(5'd9);                   expect_cyc("sat_lu", 1, PC | IFS | BUB, (i > 15) ? 15 : i, 0);
      end
      idle_in();                                   expect_cyc("sat_stall", 1, 7'b0, 15, 0);
      for (int i = 0; i < 20; i++) begin
         idle_in(); redir = 1;                     expect_cyc("sat_redir", 1, FL | BUB, 15, (i > 15) ? 15 : i);
      end
      idle_in();                                   expect_cyc("sat_flush", 1, 7'b0, 15, 15);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
